// File: rtl/light_morse_decoder.sv
// Decodes a Morse on/off light level back into characters and word gaps.
// The light is synchronized and glitch-filtered, and mark and space lengths
// are measured in clock cycles, then classified against multiples of
// DOT_CYCLES.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   light      asynchronous light level (1 = lit)
//   sym_valid  one-cycle pulse when a character completes
//   sym_bits   elements of the character, first element at bit sym_len-1,
//              0 = dot, 1 = dash
//   sym_len    number of stored elements
//   sym_err    more than MAX_ELEMS elements were seen in this character
//   word_gap   one-cycle pulse when a word gap is detected
module light_morse_decoder #(
    parameter int unsigned DOT_CYCLES    = 25000000,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter int unsigned MAX_ELEMS     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 light,
    output logic                 sym_valid,
    output logic [MAX_ELEMS-1:0] sym_bits,
    output logic [2:0]           sym_len,
    output logic                 sym_err,
    output logic                 word_gap
);

    localparam int unsigned RUN_MAX = 8 * DOT_CYCLES;
    localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);
    localparam int unsigned MEAS_W  = RUN_W + 1;
    localparam int unsigned FC_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    localparam logic [RUN_W-1:0]  RUN_SAT  = RUN_W'(RUN_MAX);
    localparam logic [MEAS_W-1:0] DASH_MIN = MEAS_W'(2 * DOT_CYCLES);
    localparam logic [MEAS_W-1:0] CHAR_GAP = MEAS_W'(3 * DOT_CYCLES);
    localparam logic [MEAS_W-1:0] WORD_GAP = MEAS_W'(7 * DOT_CYCLES);
    localparam logic [FC_W-1:0]   FC_LAST  = FC_W'(FILTER_CYCLES - 1);
    localparam logic [2:0]        LEN_FULL = 3'(MAX_ELEMS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_t;

    state_t               state;
    logic                 sync0;
    logic                 sync1;
    logic                 filt;
    logic [FC_W-1:0]      fcnt;
    logic [RUN_W-1:0]     run;
    logic [MAX_ELEMS-1:0] acc;
    logic [2:0]           len;
    logic                 ovf;

    logic                 flip_c;
    logic                 rise_c;
    logic                 fall_c;
    logic [MEAS_W-1:0]    meas_c;
    logic                 dash_c;

    // Filtered level flips on the FILTER_CYCLES-th consecutive differing sample.
    always_comb begin
        flip_c = (sync1 != filt) && (fcnt == FC_LAST);
        rise_c = flip_c && !filt;
        fall_c = flip_c && filt;
    end

    // Length of the current run including this cycle, so that a level lasting
    // N cycles measures N on the edge that ends it.
    always_comb begin
        meas_c = MEAS_W'(run) + MEAS_W'(1);
        dash_c = (meas_c >= DASH_MIN);
    end

    // Two-flop synchronizer and glitch filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            filt  <= 1'b0;
            fcnt  <= '0;
        end else begin
            sync0 <= light;
            sync1 <= sync0;
            if (sync1 == filt) begin
                fcnt <= '0;
            end else if (flip_c) begin
                filt <= ~filt;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + FC_W'(1);
            end
        end
    end

    // Run counter: restarts on every filtered edge, saturates at 8 units.
    always_ff @(posedge clk) begin
        if (rst) begin
            run <= '0;
        end else if (flip_c) begin
            run <= '0;
        end else if (run != RUN_SAT) begin
            run <= run + RUN_W'(1);
        end
    end

    // Decoder state machine with element accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            len       <= '0;
            ovf       <= 1'b0;
            sym_valid <= 1'b0;
            sym_bits  <= '0;
            sym_len   <= '0;
            sym_err   <= 1'b0;
            word_gap  <= 1'b0;
        end else begin
            sym_valid <= 1'b0;
            word_gap  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rise_c) begin
                        state <= MARK;
                    end
                end
                MARK: begin
                    if (fall_c) begin
                        state <= SPACE;
                        if (len < LEN_FULL) begin
                            acc <= (acc << 1) | MAX_ELEMS'(dash_c);
                            len <= len + 3'd1;
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                end
                SPACE: begin
                    // A rise landing exactly on the character boundary still
                    // closes the character before the next one starts.
                    if (meas_c == CHAR_GAP) begin
                        sym_valid <= 1'b1;
                        sym_bits  <= acc;
                        sym_len   <= len;
                        sym_err   <= ovf;
                        acc       <= '0;
                        len       <= '0;
                        ovf       <= 1'b0;
                    end
                    if (meas_c == WORD_GAP) begin
                        word_gap <= 1'b1;
                    end
                    if (rise_c) begin
                        state <= MARK;
                    end else if (meas_c == WORD_GAP) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
